// File: rtl/writeback_regfile_mp_if.sv
// Writeback lanes, packed register-file view and dump stream for writeback_regfile_mp.
// slave = register-file block, master = pipeline / trace consumer.
interface writeback_regfile_mp_if #(
  parameter int NUM_WB   = 2,
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int INSTR_W  = 16,
  parameter int CNT_W    = 16
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [NUM_WB-1:0]          iswb;
  logic [NUM_WB-1:0]          isld;
  logic [NUM_WB*INSTR_W-1:0]  instr;
  logic [NUM_WB*DATA_W-1:0]   ldresult;
  logic [NUM_WB*DATA_W-1:0]   aluresult;
  logic [NUM_REGS*DATA_W-1:0] regvals;
  logic [CNT_W-1:0]           wb_count;
  logic                       dump_start;
  logic                       dump_busy;
  logic                       dump_valid;
  logic                       dump_ready;
  logic [IDX_W-1:0]           dump_idx;
  logic [DATA_W-1:0]          dump_data;
  logic                       dump_last;

  modport slave (
    input  iswb, isld, instr, ldresult, aluresult, dump_start, dump_ready,
    output regvals, wb_count, dump_busy, dump_valid, dump_idx, dump_data, dump_last
  );

  modport master (
    output iswb, isld, instr, ldresult, aluresult, dump_start, dump_ready,
    input  regvals, wb_count, dump_busy, dump_valid, dump_idx, dump_data, dump_last
  );
endinterface

// File: rtl/writeback_regfile_mp.sv
// Multi-lane writeback into a clocked register file (1-cycle commit, no bypass) plus a
// valid/ready dump engine; dump stalls hold the index, writeback is never stalled.
module writeback_regfile_mp #(
  parameter int NUM_WB   = 2,
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int INSTR_W  = 16,
  parameter int DEST_LSB = 8,
  parameter int R0_ZERO  = 0,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  writeback_regfile_mp_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WCNT_W = $clog2(NUM_REGS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, SEND} dump_state_t;

  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [DATA_W-1:0]   wr_dat [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic [WCNT_W-1:0]   wr_cnt;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W-1:0]    wb_count_q;

  dump_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dump_vld;
  logic             dump_lst;
  logic [DATA_W-1:0] dump_dat;

  logic unused_instr;
  assign unused_instr = ^bus.instr;

  // Lanes scanned oldest to youngest so the youngest lane hitting a register wins.
  always_comb begin
    wr_en = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_dat[r] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (bus.iswb[k] && (bus.instr[k*INSTR_W + DEST_LSB +: IDX_W] == IDX_W'(r))) begin
          wr_en[r]  = 1'b1;
          wr_dat[r] = bus.isld[k] ? bus.ldresult[k*DATA_W +: DATA_W]
                                  : bus.aluresult[k*DATA_W +: DATA_W];
        end
      end
    end
    if (R0_ZERO != 0) wr_en[0] = 1'b0;
  end

  // One applied write per enabled register, so conflicts and r0 drops are already excluded.
  always_comb begin
    wr_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++) wr_cnt = wr_cnt + WCNT_W'(wr_en[r]);
  end

  assign cnt_sum = {1'b0, wb_count_q} + (CNT_W+1)'(wr_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      wb_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en[r]) regs[r] <= wr_dat[r];
      end
      wb_count_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dump_vld = 1'b0;
    dump_lst = 1'b0;
    dump_dat = '0;
    case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        dump_vld = 1'b1;
        dump_lst = (idx_q == LAST_IDX);
        dump_dat = regs[idx_q];
        if (bus.dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regvals
    assign bus.regvals[i*DATA_W +: DATA_W] = regs[i];
  end

  assign bus.wb_count   = wb_count_q;
  assign bus.dump_valid = dump_vld;
  assign bus.dump_busy  = dump_vld;
  assign bus.dump_last  = dump_lst;
  assign bus.dump_idx   = idx_q;
  assign bus.dump_data  = dump_dat;
endmodule

// File: tb/tb_writeback_regfile_mp.sv
// Drives one stimulus stream into an R0_ZERO=0 and an R0_ZERO=1 instance and scoreboards both
// against an array-based reference model of the register file, counter and dump stream.
module tb_writeback_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_regfile_mp_if bus0();
  writeback_regfile_mp_if bus1();

  assign bus1.iswb       = bus0.iswb;
  assign bus1.isld       = bus0.isld;
  assign bus1.instr      = bus0.instr;
  assign bus1.ldresult   = bus0.ldresult;
  assign bus1.aluresult  = bus0.aluresult;
  assign bus1.dump_start = bus0.dump_start;
  assign bus1.dump_ready = bus0.dump_ready;

  writeback_regfile_mp #(.R0_ZERO(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  writeback_regfile_mp #(.R0_ZERO(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [127:0] rv0;
    logic [127:0] rv1;
    logic [15:0]  c0;
    logic [15:0]  c1;
    logic         dv;
    logic [2:0]   idx;
    logic [15:0]  dd0;
    logic [15:0]  dd1;
    logic         after_rst;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [15:0] m_reg [2][8];
  logic [15:0] m_cnt [2];
  bit          m_act;
  int          m_idx;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: lanes applied in program order, each distinct register written counts once.
  task automatic model_step();
    exp_t e;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 8; r++) m_reg[d][r] = 16'h0;
        m_cnt[d] = 16'h0;
      end
      m_act = 0;
      m_idx = 0;
      e.after_rst = 1'b1;
    end else begin
      e.after_rst = 1'b0;
      if (!m_act) begin
        if (bus0.dump_start) begin
          m_act = 1;
          m_idx = 0;
        end
      end else if (bus0.dump_ready) begin
        if (m_idx == 7) m_act = 0;
        else m_idx++;
      end
      for (int d = 0; d < 2; d++) begin
        bit [7:0] hit;
        int n;
        hit = '0;
        for (int k = 0; k < 2; k++) begin
          int dest;
          dest = int'(bus0.instr[k*16+8 +: 3]);
          if (bus0.iswb[k] && !(d == 1 && dest == 0)) begin
            m_reg[d][dest] = bus0.isld[k] ? bus0.ldresult[k*16 +: 16] : bus0.aluresult[k*16 +: 16];
            hit[dest] = 1'b1;
          end
        end
        n = $countones(hit);
        m_cnt[d] = (int'(m_cnt[d]) + n > 65535) ? 16'hFFFF : m_cnt[d] + 16'(n);
      end
    end
    for (int r = 0; r < 8; r++) begin
      e.rv0[r*16 +: 16] = m_reg[0][r];
      e.rv1[r*16 +: 16] = m_reg[1][r];
    end
    e.c0  = m_cnt[0];
    e.c1  = m_cnt[1];
    e.dv  = m_act;
    e.idx = 3'(m_idx);
    e.dd0 = m_act ? m_reg[0][m_idx] : 16'h0;
    e.dd1 = m_act ? m_reg[1][m_idx] : 16'h0;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp("regvals0", bus0.regvals, e.rv0);
      cmp("regvals1", bus1.regvals, e.rv1);
      cmp("wb_count0", 128'(bus0.wb_count), 128'(e.c0));
      cmp("wb_count1", 128'(bus1.wb_count), 128'(e.c1));
      cmp("dump_valid0", 128'(bus0.dump_valid), 128'(e.dv));
      cmp("dump_valid1", 128'(bus1.dump_valid), 128'(e.dv));
      cmp("dump_busy0", 128'(bus0.dump_busy), 128'(e.dv));
      cmp("dump_last0", 128'(bus0.dump_last), 128'(e.dv && e.idx == 3'd7));
      cmp("dump_last1", 128'(bus1.dump_last), 128'(e.dv && e.idx == 3'd7));
      if (e.dv) begin
        cmp("dump_idx0", 128'(bus0.dump_idx), 128'(e.idx));
        cmp("dump_data0", 128'(bus0.dump_data), 128'(e.dd0));
        cmp("dump_data1", 128'(bus1.dump_data), 128'(e.dd1));
      end
      if (e.after_rst) begin
        cmp("rst_dump_idx", 128'(bus0.dump_idx), 128'(0));
        cmp("rst_dump_data", 128'(bus0.dump_data), 128'(0));
      end
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input bit wb, input bit ld, input int dest,
                          input logic [15:0] ldv, input logic [15:0] aluv);
    logic [15:0] t;
    t = 16'($urandom);
    t[10:8] = 3'(dest);
    bus0.iswb[k] = wb;
    bus0.isld[k] = ld;
    bus0.instr[k*16 +: 16]     = t;
    bus0.ldresult[k*16 +: 16]  = ldv;
    bus0.aluresult[k*16 +: 16] = aluv;
  endtask

  task automatic no_wb();
    bus0.iswb = 2'b00;
  endtask

  function automatic logic [15:0] reg0v(input int i);
    return bus0.regvals[i*16 +: 16];
  endfunction

  initial begin
    rst = 1'b1;
    bus0.iswb = '0; bus0.isld = '0; bus0.instr = '0;
    bus0.ldresult = '0; bus0.aluresult = '0;
    bus0.dump_start = 1'b0; bus0.dump_ready = 1'b0;
    step(); step();
    cmp("reset_count", 128'(bus0.wb_count), 128'(0));
    cmp("reset_valid", 128'(bus0.dump_valid), 128'(0));
    rst = 1'b0;

    set_lane(0, 1, 0, 3, 16'h0000, 16'hBEEF); set_lane(1, 0, 0, 0, 16'h0, 16'h0);
    step(); no_wb();
    cmp("t1_reg3", 128'(reg0v(3)), 128'(16'hBEEF));
    cmp("t1_count", 128'(bus0.wb_count), 128'(1));

    set_lane(0, 1, 1, 5, 16'h1111, 16'h0); set_lane(1, 1, 0, 5, 16'h0, 16'h2222);
    step(); no_wb();
    cmp("t2_reg5", 128'(reg0v(5)), 128'(16'h2222));
    cmp("t2_count", 128'(bus0.wb_count), 128'(2));

    set_lane(0, 1, 1, 2, 16'h00AA, 16'h0); set_lane(1, 1, 0, 6, 16'h0, 16'h00BB);
    step(); no_wb();
    cmp("t3_reg2", 128'(reg0v(2)), 128'(16'h00AA));
    cmp("t3_reg6", 128'(reg0v(6)), 128'(16'h00BB));
    cmp("t3_count", 128'(bus0.wb_count), 128'(4));

    set_lane(0, 1, 0, 0, 16'h0, 16'hFFFF); set_lane(1, 0, 0, 0, 16'h0, 16'h0);
    step(); no_wb();
    cmp("t4_r0zero_reg0", 128'(bus1.regvals[15:0]), 128'(0));
    cmp("t4_r0zero_count", 128'(bus1.wb_count), 128'(4));
    cmp("t4_plain_reg0", 128'(reg0v(0)), 128'(16'hFFFF));

    for (int j = 0; j < 4; j++) begin
      set_lane(0, 1, 0, 2*j,   16'h0, 16'(16'h1000 + 2*j));
      set_lane(1, 1, 1, 2*j+1, 16'(16'h1000 + 2*j + 1), 16'h0);
      step();
    end
    no_wb();
    bus0.dump_start = 1'b1; bus0.dump_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      cmp("t5_idx", 128'(bus0.dump_idx), 128'(i));
      cmp("t5_data", 128'(bus0.dump_data), 128'(16'h1000 + i));
      cmp("t5_last", 128'(bus0.dump_last), 128'(i == 7));
      step();
    end
    bus0.dump_start = 1'b0;
    cmp("t5_busy_after", 128'(bus0.dump_busy), 128'(0));
    step();

    bus0.dump_start = 1'b1; step(); bus0.dump_start = 1'b0;
    step(); step();
    bus0.dump_ready = 1'b0;
    set_lane(0, 1, 0, 2, 16'h0, 16'h5A5A);
    step(); no_wb(); step(); step();
    cmp("t6_idx_held", 128'(bus0.dump_idx), 128'(2));
    cmp("t6_data_tracks", 128'(bus0.dump_data), 128'(16'h5A5A));
    bus0.dump_ready = 1'b1;
    step(); step();
    cmp("t6_idx4", 128'(bus0.dump_idx), 128'(4));
    rst = 1'b1; step(); rst = 1'b0;
    cmp("t6_rst_valid", 128'(bus0.dump_valid), 128'(0));
    cmp("t6_rst_busy", 128'(bus0.dump_busy), 128'(0));

    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++)
        set_lane(k, 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                 16'($urandom), 16'($urandom));
      bus0.dump_start = ($urandom_range(0, 7) == 0);
      bus0.dump_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; bus0.dump_start = 1'b0;

    for (int c = 0; c < 32770; c++) begin
      set_lane(0, 1, 0, 1, 16'h0, 16'($urandom));
      set_lane(1, 1, 1, 2, 16'($urandom), 16'h0);
      step();
    end
    no_wb();
    cmp("sat_count0", 128'(bus0.wb_count), 128'(16'hFFFF));
    cmp("sat_count1", 128'(bus1.wb_count), 128'(16'hFFFF));
    step();

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
